// File: rtl/wb_mem_arbiter.sv
// Two-master / one-slave wishbone arbiter in front of the core's single-ported word memory.
// Contention policy: define ARB_ROUND_ROBIN_EN for round-robin, otherwise master 1 has fixed priority.
module wb_mem_arbiter #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] IDLE_DATA      = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_stb,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  input  logic        i_m0_we,
  input  logic [2:0]  i_m0_sel,
  output logic [31:0] o_m0_data,
  output logic        o_m0_ack,
  output logic        o_m0_stall,
  output logic        o_m0_err,
  input  logic        i_m1_stb,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  input  logic        i_m1_we,
  input  logic [2:0]  i_m1_sel,
  output logic [31:0] o_m1_data,
  output logic        o_m1_ack,
  output logic        o_m1_stall,
  output logic        o_m1_err,
  output logic        o_s_stb,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_data,
  output logic        o_s_we,
  output logic [2:0]  o_s_sel,
  input  logic [31:0] i_s_data,
  input  logic        i_s_ack,
  input  logic        i_s_stall
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [16:0] CNT_LAST = 17'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        owner;
  logic [16:0] wait_cnt;
  logic        win;
  logic        any_req;
  logic        slave_done;
  logic        timed_out;
  logic        route_ack;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;
`endif

  assign any_req = i_m0_stb | i_m1_stb;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    win = i_m1_stb;
    if (i_m0_stb && i_m1_stb) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = ~last_grant;
`else
      win = 1'b1;
`endif
    end
  end

  // Only the contention loser is stalled while idle; a busy arbiter stalls both masters.
  always_comb begin
    o_m0_stall = 1'b0;
    o_m1_stall = 1'b0;
    if (!i_reset) begin
      if (state == S_IDLE) begin
        o_m0_stall = i_m0_stb & win;
        o_m1_stall = i_m1_stb & ~win;
      end else begin
        o_m0_stall = 1'b1;
        o_m1_stall = 1'b1;
      end
    end
  end

  // A slave ack wins over a timeout that would expire in the same cycle.
  assign slave_done = (state == S_WAIT) & i_s_ack;
  assign timed_out  = (state == S_WAIT) & ~i_s_ack & (wait_cnt == CNT_LAST);
  assign route_ack  = slave_done | timed_out;

  assign o_m0_ack  = route_ack & ~owner;
  assign o_m1_ack  = route_ack & owner;
  assign o_m0_err  = timed_out & ~owner;
  assign o_m1_err  = timed_out & owner;
  assign o_m0_data = (slave_done && !owner) ? i_s_data : IDLE_DATA;
  assign o_m1_data = (slave_done && owner)  ? i_s_data : IDLE_DATA;
  assign o_s_stb   = (state == S_ISSUE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_IDLE;
      owner    <= 1'b0;
      wait_cnt <= '0;
      o_s_addr <= '0;
      o_s_data <= '0;
      o_s_we   <= 1'b0;
      o_s_sel  <= 3'b010;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner    <= win;
            o_s_addr <= win ? i_m1_addr : i_m0_addr;
            o_s_data <= win ? i_m1_data : i_m0_data;
            o_s_we   <= win ? i_m1_we   : i_m0_we;
            o_s_sel  <= win ? i_m1_sel  : i_m0_sel;
            state    <= S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= win;
`endif
          end
        end
        S_ISSUE: begin
          if (!i_s_stall) begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 17'd1;
          if (route_ack) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: arbitration table, directed multi-cycle sequences and a
// randomized run against a transaction-level model. Follows ARB_ROUND_ROBIN_EN like the design.
module tb_wb_mem_arbiter;
  localparam int          TO   = 8;
  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_m0_stb, i_m0_we, i_m1_stb, i_m1_we;
  logic [31:0] i_m0_addr, i_m0_data, i_m1_addr, i_m1_data;
  logic [2:0]  i_m0_sel, i_m1_sel;
  logic [31:0] o_m0_data, o_m1_data;
  logic        o_m0_ack, o_m0_stall, o_m0_err, o_m1_ack, o_m1_stall, o_m1_err;
  logic        o_s_stb, o_s_we;
  logic [31:0] o_s_addr, o_s_data;
  logic [2:0]  o_s_sel;
  logic [31:0] i_s_data;
  logic        i_s_ack, i_s_stall;

  wb_mem_arbiter #(.TIMEOUT_CYCLES(TO), .IDLE_DATA(IDLE)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_stb(i_m0_stb), .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_we(i_m0_we),
    .i_m0_sel(i_m0_sel), .o_m0_data(o_m0_data), .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall),
    .o_m0_err(o_m0_err),
    .i_m1_stb(i_m1_stb), .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_we(i_m1_we),
    .i_m1_sel(i_m1_sel), .o_m1_data(o_m1_data), .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall),
    .o_m1_err(o_m1_err),
    .o_s_stb(o_s_stb), .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_we(o_s_we),
    .o_s_sel(o_s_sel), .i_s_data(i_s_data), .i_s_ack(i_s_ack), .i_s_stall(i_s_stall)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic m0_stb, m1_stb, exp_stall0, exp_stall1;
  } arb_vec_t;

  typedef struct {
    logic v; logic [31:0] addr, data; logic we; logic [2:0] sel;
  } req_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] slave_mem [256];
  logic [31:0] ref_mem [256];
  int          ack_at = -1;
  logic        slave_mute = 1'b0;
  logic [31:0] slave_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory behaviour: accepts a strobe when not stalling and acks two cycles later.
  task automatic slave_sample();
    if (o_s_stb && !i_s_stall) begin
      ack_at = cyc + 2;
      if (o_s_we) slave_mem[o_s_addr[9:2]] = o_s_data;
      slave_rdata = slave_mem[o_s_addr[9:2]];
    end
  endtask

  task automatic next_cycle();
    slave_sample();
    @(posedge i_clk);
    #1;
    cyc++;
    i_s_ack  = (cyc == ack_at) && !slave_mute;
    i_s_data = i_s_ack ? slave_rdata : 32'hDEAD_BEEF;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_m(input int m, input logic stb, input logic [31:0] addr,
                       input logic [31:0] data, input logic we, input logic [2:0] sel);
    if (m == 0) begin
      i_m0_stb = stb; i_m0_addr = addr; i_m0_data = data; i_m0_we = we; i_m0_sel = sel;
    end else begin
      i_m1_stb = stb; i_m1_addr = addr; i_m1_data = data; i_m1_we = we; i_m1_sel = sel;
    end
  endtask

  task automatic apply_reset();
    i_reset = 1'b1; i_m0_stb = 1'b0; i_m1_stb = 1'b0; i_s_stall = 1'b0;
    slave_mute = 1'b0; ack_at = -1;
    repeat (2) begin
      @(posedge i_clk);
      #1;
      cyc++;
    end
    i_reset = 1'b0; i_s_ack = 1'b0; i_s_data = 32'hDEAD_BEEF;
  endtask

  function automatic logic [2:0] rand_sel();
    case ($urandom_range(0, 4))
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b010;
      3:       return 3'b100;
      default: return 3'b101;
    endcase
  endfunction

  arb_vec_t    vecs [4];
  req_t        pend [2];
  req_t        exp_req;
  logic        first_m, drop0, drop1, idle, both, w, exp_owner;
  logic [31:0] exp_data, v;
  int          acc [2];
  int          ackc [2];
  logic [31:0] rd0;
  int          free_at, exp_s_cyc, exp_ack_cyc, k;
  logic [31:0] b2b_val [3];
`ifdef ARB_ROUND_ROBIN_EN
  logic        model_last;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      slave_mem[i] = v;
      ref_mem[i] = v;
    end
    set_m(0, 1'b0, '0, '0, 1'b0, 3'b010);
    set_m(1, 1'b0, '0, '0, 1'b0, 3'b010);
    i_s_stall = 1'b0; i_s_data = 32'h1234_5678;
    // A slave ack during reset must not reach any master.
    i_reset = 1'b1; i_s_ack = 1'b1;
    #2;
    check1("reset s_stb", o_s_stb, 1'b0);
    check("reset s_addr", o_s_addr, 32'h0);
    check("reset s_data", o_s_data, 32'h0);
    check1("reset s_we", o_s_we, 1'b0);
    check("reset s_sel", 32'(o_s_sel), 32'h2);
    check1("reset m0_ack", o_m0_ack, 1'b0);
    check1("reset m1_ack", o_m1_ack, 1'b0);
    check1("reset m0_err", o_m0_err, 1'b0);
    check("reset m0_data", o_m0_data, IDLE);
    check("reset m1_data", o_m1_data, IDLE);
    check1("reset m0_stall", o_m0_stall, 1'b0);
    check1("reset m1_stall", o_m1_stall, 1'b0);
    apply_reset();

    // Idle arbitration table; strobes drop before the edge so nothing is accepted.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
`ifdef ARB_ROUND_ROBIN_EN
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
`else
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      i_m0_stb = vecs[i].m0_stb;
      i_m1_stb = vecs[i].m1_stb;
      settle();
      check1("table m0_stall", o_m0_stall, vecs[i].exp_stall0);
      check1("table m1_stall", o_m1_stall, vecs[i].exp_stall1);
      check1("table s_stb", o_s_stb, 1'b0);
      i_m0_stb = 1'b0; i_m1_stb = 1'b0;
      next_cycle();
    end

    // Single read: accept N, strobe N+1, ack N+3.
    slave_mem[4] = 32'h0000_ABCD; ref_mem[4] = 32'h0000_ABCD;
    set_m(0, 1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
    settle();
    check1("rd accept stall", o_m0_stall, 1'b0);
    next_cycle(); i_m0_stb = 1'b0; settle();
    check1("rd s_stb", o_s_stb, 1'b1);
    check("rd s_addr", o_s_addr, 32'h10);
    check1("rd s_we", o_s_we, 1'b0);
    check("rd s_sel", 32'(o_s_sel), 32'h2);
    next_cycle(); settle();
    check1("rd early ack", o_m0_ack, 1'b0);
    next_cycle(); settle();
    check1("rd ack", o_m0_ack, 1'b1);
    check("rd data", o_m0_data, 32'h0000_ABCD);
    check1("rd err", o_m0_err, 1'b0);
    check1("rd m1_ack", o_m1_ack, 1'b0);
    check("rd m1_data", o_m1_data, IDLE);
    check1("rd stb in ack cycle", o_s_stb, 1'b0);
    next_cycle();

    // Contention right after reset.
    apply_reset();
`ifdef ARB_ROUND_ROBIN_EN
    first_m = 1'b0;
`else
    first_m = 1'b1;
`endif
    set_m(0, 1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
    set_m(1, 1'b1, 32'h20, 32'h1234_5678, 1'b1, 3'b010);
    acc = '{-1, -1}; ackc = '{-1, -1}; rd0 = '0;
    for (int i = 0; i < 10; i++) begin
      settle();
      drop0 = i_m0_stb && !o_m0_stall;
      drop1 = i_m1_stb && !o_m1_stall;
      if (drop0) acc[0] = i;
      if (drop1) acc[1] = i;
      if (o_m0_ack) begin ackc[0] = i; rd0 = o_m0_data; end
      if (o_m1_ack) ackc[1] = i;
      if (o_m0_ack || o_m1_ack) check1("cont stb in ack cycle", o_s_stb, 1'b0);
      next_cycle();
      if (drop0) i_m0_stb = 1'b0;
      if (drop1) i_m1_stb = 1'b0;
    end
    check("cont first accept", acc[first_m], 0);
    check("cont first ack", ackc[first_m], 3);
    check("cont second accept", acc[!first_m], 4);
    check("cont second ack", ackc[!first_m], 7);
    check("cont m0 read data", rd0, 32'h0000_ABCD);
    check("cont m1 write landed", slave_mem[8], 32'h1234_5678);
    ref_mem[8] = 32'h1234_5678;

    // Back-to-back requests from master 1, accepted every four cycles.
    b2b_val = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
    for (int j = 0; j < 3; j++) begin
      slave_mem[16 + j] = b2b_val[j]; ref_mem[16 + j] = b2b_val[j];
    end
    k = 0;
    set_m(1, 1'b1, 32'h40, 32'h0, 1'b0, 3'b010);
    for (int i = 0; i < 12; i++) begin
      settle();
      check1("b2b stall", o_m1_stall, (i % 4) != 0);
      check1("b2b ack", o_m1_ack, (i % 4) == 3);
      if ((i % 4) == 3) check("b2b data", o_m1_data, b2b_val[i / 4]);
      check1("b2b stb with ack", o_s_stb && o_m1_ack, 1'b0);
      next_cycle();
      if ((i % 4) == 0) begin
        k++;
        if (k < 3) i_m1_addr = 32'h40 + 32'(4 * k);
        else i_m1_stb = 1'b0;
      end
    end

    // Slave stall for five cycles in S_ISSUE.
    set_m(0, 1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
    settle();
    check1("sstall accept", o_m0_stall, 1'b0);
    next_cycle(); i_m0_stb = 1'b0; i_s_stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      settle();
      check1("sstall s_stb held", o_s_stb, 1'b1);
      check("sstall s_addr held", o_s_addr, 32'h10);
      next_cycle();
    end
    i_s_stall = 1'b0;
    settle();
    check1("sstall s_stb release", o_s_stb, 1'b1);
    next_cycle(); settle();
    check1("sstall no early ack", o_m0_ack, 1'b0);
    next_cycle(); settle();
    check1("sstall ack", o_m0_ack, 1'b1);
    check("sstall data", o_m0_data, 32'h0000_ABCD);
    next_cycle();

    // Timeout: first wait cycle is N+2, error ack in the TO-th wait cycle, late ack 3 cycles on.
    slave_mute = 1'b1;
    set_m(0, 1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
    settle();
    next_cycle(); i_m0_stb = 1'b0;
    for (int i = 1; i <= 2 + TO + 2; i++) begin
      if (i == 2 + TO + 2) begin i_s_ack = 1'b1; i_s_data = 32'h5555_AAAA; end
      settle();
      check1("timeout ack", o_m0_ack, i == 2 + TO - 1);
      check1("timeout err", o_m0_err, i == 2 + TO - 1);
      check("timeout data", o_m0_data, IDLE);
      check1("timeout m1_ack", o_m1_ack, 1'b0);
      next_cycle();
    end
    slave_mute = 1'b0;

    // Async reset in S_WAIT; the slave ack arriving after release is dropped.
    set_m(0, 1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
    settle();
    next_cycle(); i_m0_stb = 1'b0;
    next_cycle();
    #1; i_reset = 1'b1; #1;
    check1("midrst s_stb", o_s_stb, 1'b0);
    check("midrst s_addr", o_s_addr, 32'h0);
    check("midrst s_sel", 32'(o_s_sel), 32'h2);
    check1("midrst m0_stall", o_m0_stall, 1'b0);
    next_cycle();
    i_reset = 1'b0;
    settle();
    check1("midrst slave ack seen", i_s_ack, 1'b1);
    check1("midrst late m0_ack", o_m0_ack, 1'b0);
    check("midrst m0_data", o_m0_data, IDLE);
    next_cycle();
    slave_mem[12] = 32'hCAFE_0001; ref_mem[12] = 32'hCAFE_0001;
    set_m(0, 1'b1, 32'h30, 32'h0, 1'b0, 3'b010);
    settle();
    check1("postrst accept", o_m0_stall, 1'b0);
    next_cycle(); i_m0_stb = 1'b0;
    next_cycle();
    next_cycle(); settle();
    check1("postrst ack", o_m0_ack, 1'b1);
    check("postrst data", o_m0_data, 32'hCAFE_0001);
    next_cycle();

    // Randomized traffic against a transaction-level schedule model.
    apply_reset();
    pend[0].v = 1'b0; pend[1].v = 1'b0;
    free_at = cyc; exp_s_cyc = -1; exp_ack_cyc = -1; exp_owner = 1'b0; exp_data = '0;
    exp_req = '{1'b0, 32'h0, 32'h0, 1'b0, 3'b010};
`ifdef ARB_ROUND_ROBIN_EN
    model_last = 1'b1;
`endif
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (pend[m].v && $urandom_range(0, 99) < 4) begin
          pend[m].v = 1'b0;
        end else if (!pend[m].v && $urandom_range(0, 99) < 35) begin
          pend[m] = '{1'b1, 32'($urandom_range(0, 255)) << 2, $urandom, 1'($urandom), rand_sel()};
        end
      end
      set_m(0, pend[0].v, pend[0].addr, pend[0].data, pend[0].we, pend[0].sel);
      set_m(1, pend[1].v, pend[1].addr, pend[1].data, pend[1].we, pend[1].sel);
      settle();
      idle = (cyc >= free_at);
      both = pend[0].v && pend[1].v;
`ifdef ARB_ROUND_ROBIN_EN
      w = both ? !model_last : pend[1].v;
`else
      w = pend[1].v;
`endif
      check1("rnd m0_stall", o_m0_stall, idle ? (both && w) : 1'b1);
      check1("rnd m1_stall", o_m1_stall, idle ? (both && !w) : 1'b1);
      check1("rnd s_stb", o_s_stb, cyc == exp_s_cyc);
      if (cyc == exp_s_cyc) begin
        check("rnd s_addr", o_s_addr, exp_req.addr);
        check1("rnd s_we", o_s_we, exp_req.we);
        check("rnd s_sel", 32'(o_s_sel), 32'(exp_req.sel));
        if (exp_req.we) check("rnd s_data", o_s_data, exp_req.data);
      end
      check1("rnd m0_ack", o_m0_ack, (cyc == exp_ack_cyc) && !exp_owner);
      check1("rnd m1_ack", o_m1_ack, (cyc == exp_ack_cyc) && exp_owner);
      check("rnd m0_data", o_m0_data, ((cyc == exp_ack_cyc) && !exp_owner) ? exp_data : IDLE);
      check("rnd m1_data", o_m1_data, ((cyc == exp_ack_cyc) && exp_owner) ? exp_data : IDLE);
      check1("rnd err", o_m0_err | o_m1_err, 1'b0);
      if (idle && (pend[0].v || pend[1].v)) begin
        exp_req = pend[w];
        exp_owner = w;
        exp_s_cyc = cyc + 1;
        exp_ack_cyc = cyc + 3;
        free_at = cyc + 4;
        if (exp_req.we) ref_mem[exp_req.addr[9:2]] = exp_req.data;
        exp_data = ref_mem[exp_req.addr[9:2]];
`ifdef ARB_ROUND_ROBIN_EN
        model_last = w;
`endif
        pend[w].v = 1'b0;
      end
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
